depp_host: RTL and testbench
============================

Name: depp_host

Overview:
- DEPP (EPP-style) bus initiator: the host end of the parallel port link.
- Turns single-byte commands into address-write, data-write and data-read bus cycles, completing each with the wait handshake.
- Lets one FPGA drive a DEPP peripheral port on another board. Also serves as the bus driver in bench models of the peripheral side.
- The tristate buffer lives at the top level; this block supplies data-out, output-enable and data-in.

Parameters:
- SETUP_CLKS, 2: clocks that o_write_n and o_depp are stable before the strobe falls (1..15).
- IDLE_CLKS, 4: minimum clocks with both strobes high between cycles (1..15). Default meets 40 ns at 100 MHz.
- TIMEOUT_CLKS, 1023: clocks allowed in STROBE or in RELEASE before the cycle is aborted. Counter is 10 bits wide.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_cmd_stb  in  1  command request; accepted when high and o_cmd_busy low
- i_cmd_rd  in  1  1 = data read, 0 = write
- i_cmd_addr  in  1  1 = address cycle (astb), 0 = data cycle (dstb). Read with addr=1 is treated as an address write.
- i_cmd_data  in  8  write byte
- o_cmd_busy  out  1  high from the acceptance cycle until GAP completes
- o_rsp_stb  out  1  one-clock completion pulse
- o_rsp_err  out  1  valid with o_rsp_stb; 1 = timeout
- o_rsp_data  out  8  read byte, valid with o_rsp_stb on successful reads; otherwise holds its previous value
- o_astb_n  out  1  address strobe, active low
- o_dstb_n  out  1  data strobe, active low
- o_write_n  out  1  0 = write cycle
- o_depp  out  8  bus output data
- o_depp_oe  out  1  1 = drive the bus
- i_depp  in  8  bus input data, asynchronous
- i_wait  in  1  peripheral wait, asynchronous

Behaviour:
- Reset values: o_astb_n=1, o_dstb_n=1, o_write_n=1, o_depp_oe=0, o_depp=8'h00, o_cmd_busy=0, o_rsp_stb=0, o_rsp_err=0, o_rsp_data=8'h00, state IDLE.
- Synchroniser: i_wait and i_depp pass through a 2-flop synchroniser (s_wait, s_depp). All decisions use s_wait only.
- All outputs are registered.
- IDLE:
  - On i_cmd_stb, latch the command and set o_cmd_busy=1 in that same clock edge.
  - Writes: o_write_n=0, o_depp=i_cmd_data, o_depp_oe=1.
  - Reads: o_write_n=1, o_depp_oe=0.
  - Load counter with SETUP_CLKS-1 and go to SETUP.
- SETUP: count down. At 0, drive the selected strobe low (o_astb_n or o_dstb_n, never both), clear the counter, go to STROBE.
- STROBE:
  - When s_wait=1: on reads capture s_depp into o_rsp_data; raise the strobe; go to RELEASE.
  - If the counter reaches TIMEOUT_CLKS first: raise the strobe, set err flag, go to GAP.
- RELEASE:
  - When s_wait=0: o_write_n=1, o_depp_oe=0, pulse o_rsp_stb with o_rsp_err=0, go to GAP.
  - On timeout: same exit but with o_rsp_err=1.
- GAP:
  - A timeout from STROBE emits its o_rsp_stb/o_rsp_err=1 on GAP entry.
  - Hold strobes high for IDLE_CLKS clocks, then o_cmd_busy=0 and go to IDLE.
  - A new command is accepted no earlier than the cycle after busy drops.
- i_cmd_stb while busy is ignored (not queued).
- s_wait already high in SETUP does not advance the state; it is only sampled in STROBE.
- Exactly one o_rsp_stb per accepted command.
- i_rst mid-cycle: next edge forces all reset values. The strobe rises immediately, the bus is released, and no o_rsp_stb is issued for the aborted command.
- i_rst has priority over every other input.

Test Plan:
- Address write 8'h00, responder model raises wait 3 clk after astb low and drops it 3 clk after astb high.
  - Required: o_astb_n low exactly SETUP_CLKS after acceptance, o_write_n=0, o_depp=8'h00.
  - Required: one o_rsp_stb with err=0, and o_dstb_n never low.
- Data read, responder drives 8'hA5 with wait.
  - Required: o_depp_oe=0 throughout, o_rsp_data=8'hA5, o_rsp_stb with err=0.
- Two back-to-back data writes 8'h12, 8'h34.
  - Required: strobes both high for at least IDLE_CLKS clocks between cycles.
  - Required: second command ignored while o_cmd_busy=1; second o_depp=8'h34 after re-issue.
- Responder never raises wait.
  - Required: strobe released after TIMEOUT_CLKS clocks, o_rsp_stb with o_rsp_err=1, block back in IDLE after IDLE_CLKS.
- Responder raises wait but holds it high.
  - Required: RELEASE timeout gives o_rsp_err=1, and o_depp_oe=0 afterwards.
- i_rst asserted while o_dstb_n=0.
  - Required: next clock o_dstb_n=1, o_depp_oe=0, o_cmd_busy=0, no o_rsp_stb.
  - Required: next command completes normally.

Source files
------------

// File: rtl/depp_host.sv
// DEPP (EPP-style) bus initiator: turns single-byte commands into address-write,
// data-write and data-read cycles closed by the peripheral wait handshake.
module depp_host #(
    parameter int unsigned SETUP_CLKS   = 2,
    parameter int unsigned IDLE_CLKS    = 4,
    parameter int unsigned TIMEOUT_CLKS = 1023
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_stb,
    input  logic       i_cmd_rd,
    input  logic       i_cmd_addr,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_busy,
    output logic       o_rsp_stb,
    output logic       o_rsp_err,
    output logic [7:0] o_rsp_data,
    output logic       o_astb_n,
    output logic       o_dstb_n,
    output logic       o_write_n,
    output logic [7:0] o_depp,
    output logic       o_depp_oe,
    input  logic [7:0] i_depp,
    input  logic       i_wait
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;

    localparam logic [9:0] SETUP_LOAD = 10'(SETUP_CLKS - 1);
    localparam logic [9:0] GAP_LAST   = 10'(IDLE_CLKS - 1);
    localparam logic [9:0] TO_LAST    = 10'(TIMEOUT_CLKS - 1);

    logic [2:0] state;
    logic [9:0] cnt;
    logic       wait_meta;
    logic       s_wait;
    logic [7:0] depp_meta;
    logic [7:0] s_depp;
    logic       cmd_rd;
    logic       cmd_addr;
    logic [7:0] rd_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_meta <= 1'b0;
            s_wait    <= 1'b0;
            depp_meta <= '0;
            s_depp    <= '0;
        end else begin
            wait_meta <= i_wait;
            s_wait    <= wait_meta;
            depp_meta <= i_depp;
            s_depp    <= depp_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cmd_rd     <= 1'b0;
            cmd_addr   <= 1'b0;
            rd_data    <= '0;
            o_cmd_busy <= 1'b0;
            o_rsp_stb  <= 1'b0;
            o_rsp_err  <= 1'b0;
            o_rsp_data <= '0;
            o_astb_n   <= 1'b1;
            o_dstb_n   <= 1'b1;
            o_write_n  <= 1'b1;
            o_depp     <= '0;
            o_depp_oe  <= 1'b0;
        end else begin
            o_rsp_stb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_cmd_stb) begin
                        // A read addressed to the address register is issued as an address write.
                        cmd_rd     <= i_cmd_rd & ~i_cmd_addr;
                        cmd_addr   <= i_cmd_addr;
                        o_cmd_busy <= 1'b1;
                        if (i_cmd_rd & ~i_cmd_addr) begin
                            o_write_n <= 1'b1;
                            o_depp_oe <= 1'b0;
                        end else begin
                            o_write_n <= 1'b0;
                            o_depp    <= i_cmd_data;
                            o_depp_oe <= 1'b1;
                        end
                        cnt   <= SETUP_LOAD;
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        if (cmd_addr) o_astb_n <= 1'b0;
                        else          o_dstb_n <= 1'b0;
                        cnt   <= '0;
                        state <= ST_STROBE;
                    end else begin
                        cnt <= cnt - 10'd1;
                    end
                end
                ST_STROBE: begin
                    if (s_wait) begin
                        if (cmd_rd) rd_data <= s_depp;
                        o_astb_n <= 1'b1;
                        o_dstb_n <= 1'b1;
                        cnt      <= '0;
                        state    <= ST_RELEASE;
                    end else if (cnt == TO_LAST) begin
                        // Strobe timeout reports on entry to GAP and frees the bus there too.
                        o_astb_n  <= 1'b1;
                        o_dstb_n  <= 1'b1;
                        o_write_n <= 1'b1;
                        o_depp_oe <= 1'b0;
                        o_rsp_stb <= 1'b1;
                        o_rsp_err <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_GAP;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                ST_RELEASE: begin
                    if (!s_wait || cnt == TO_LAST) begin
                        o_write_n <= 1'b1;
                        o_depp_oe <= 1'b0;
                        o_rsp_stb <= 1'b1;
                        o_rsp_err <= s_wait;
                        if (!s_wait && cmd_rd) o_rsp_data <= rd_data;
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        o_cmd_busy <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_depp_host.sv
// Self-checking bench for depp_host: table vectors, a mid-cycle reset sequence and
// randomized commands against a command-level reference model with a responder.
module tb_depp_host;

    localparam int SETUP_CLKS   = 2;
    localparam int IDLE_CLKS    = 4;
    localparam int TIMEOUT_CLKS = 1023;

    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_HOLD   = 2;

    logic       i_clk;
    logic       i_rst;
    logic       i_cmd_stb;
    logic       i_cmd_rd;
    logic       i_cmd_addr;
    logic [7:0] i_cmd_data;
    logic       o_cmd_busy;
    logic       o_rsp_stb;
    logic       o_rsp_err;
    logic [7:0] o_rsp_data;
    logic       o_astb_n;
    logic       o_dstb_n;
    logic       o_write_n;
    logic [7:0] o_depp;
    logic       o_depp_oe;
    logic [7:0] i_depp;
    logic       i_wait;

    int checks   = 0;
    int failures = 0;
    int hi_run   = 1000;
    logic [7:0] model_rsp_data = 8'h00;

    depp_host #(
        .SETUP_CLKS(SETUP_CLKS),
        .IDLE_CLKS(IDLE_CLKS),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_cmd_stb(i_cmd_stb),
        .i_cmd_rd(i_cmd_rd),
        .i_cmd_addr(i_cmd_addr),
        .i_cmd_data(i_cmd_data),
        .o_cmd_busy(o_cmd_busy),
        .o_rsp_stb(o_rsp_stb),
        .o_rsp_err(o_rsp_err),
        .o_rsp_data(o_rsp_data),
        .o_astb_n(o_astb_n),
        .o_dstb_n(o_dstb_n),
        .o_write_n(o_write_n),
        .o_depp(o_depp),
        .o_depp_oe(o_depp_oe),
        .i_depp(i_depp),
        .i_wait(i_wait)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // One command from a negedge until busy drops, with the responder run each cycle.
    task automatic run_cmd(input logic rd, input logic addr, input logic [7:0] data,
                           input int mode, input int rise, input int fall,
                           input logic [7:0] resp, input logic poke,
                           input logic exp_err, input logic [7:0] exp_data);
        int t, t_fall, t_rise, t_rsp, nrsp, lo, hi, bus_bad, wrong_low;
        logic acc, done, wr_eff, got_err;
        logic [7:0] got_data;
        wr_eff = !(rd && !addr);
        t = 0; t_fall = -1; t_rise = -1; t_rsp = -1;
        nrsp = 0; lo = 0; hi = 0; bus_bad = 0; wrong_low = 0;
        acc = 1'b0; done = 1'b0; got_err = 1'b0; got_data = 8'h00;
        i_cmd_rd = rd; i_cmd_addr = addr; i_cmd_data = data; i_cmd_stb = 1'b1;
        i_depp = resp; i_wait = 1'b0;
        while (!done && t < 4000) begin
            @(negedge i_clk);
            t++;
            if (t == 1) begin
                acc = o_cmd_busy;
                i_cmd_stb = 1'b0;
            end
            if (poke && t == 2) begin
                i_cmd_stb = 1'b1; i_cmd_rd = 1'b0; i_cmd_data = 8'h34;
            end
            if (poke && t == 3) i_cmd_stb = 1'b0;
            if (!wr_eff && o_depp_oe) bus_bad++;
            if (!o_astb_n || !o_dstb_n) begin
                if (t_fall < 0) begin
                    t_fall = t;
                    chk("idle_gap_before_strobe", int'(hi_run >= IDLE_CLKS), 1);
                end
                if (addr ? !o_dstb_n : !o_astb_n) wrong_low++;
                if (o_write_n != !wr_eff) bus_bad++;
                if (wr_eff && (!o_depp_oe || o_depp != data)) bus_bad++;
                hi_run = 0;
            end else begin
                hi_run++;
                if (t_fall >= 0 && t_rise < 0) t_rise = t;
            end
            if (o_rsp_stb) begin
                nrsp++;
                t_rsp = t;
                got_err = o_rsp_err;
                got_data = o_rsp_data;
                if (o_depp_oe || !o_write_n) bus_bad++;
            end
            if (t > 1 && !o_cmd_busy) done = 1'b1;
            if (!o_astb_n || !o_dstb_n) begin
                lo++; hi = 0;
                if (mode != M_NEVER && lo >= rise) i_wait = 1'b1;
            end else begin
                lo = 0;
                if (i_wait && mode == M_NORMAL) begin
                    hi++;
                    if (hi >= fall) begin i_wait = 1'b0; hi = 0; end
                end
            end
        end
        chk("cmd_completes", int'(done), 1);
        chk("accepted", int'(acc), 1);
        chk("setup_clks", t_fall - 1, SETUP_CLKS);
        chk("wrong_strobe_low", wrong_low, 0);
        chk("bus_values", bus_bad, 0);
        chk("rsp_count", nrsp, 1);
        chk("rsp_err", int'(got_err), int'(exp_err));
        chk("rsp_data", int'(got_data), int'(exp_data));
        chk("gap_clks", t - t_rsp, IDLE_CLKS);
        if (mode == M_NEVER) chk("strobe_timeout_clks", t_rise - t_fall, TIMEOUT_CLKS);
        if (mode == M_HOLD)  chk("release_timeout_clks", t_rsp - t_rise, TIMEOUT_CLKS);
        if (mode == M_HOLD) begin
            i_wait = 1'b0;
            repeat (3) begin
                @(negedge i_clk);
                hi_run++;
            end
        end
    endtask

    typedef struct {
        logic       rd;
        logic       addr;
        logic [7:0] data;
        int         mode;
        int         rise;
        int         fall;
        logic [7:0] resp;
        logic       poke;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n, nrsp;
        logic r_rd, r_addr, r_err;
        logic [7:0] r_data, r_resp;
        int r_mode, sel;

        tbl[0] = '{1'b0, 1'b1, 8'h00, M_NORMAL, 3, 3, 8'hFF, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 8'h00, M_NORMAL, 3, 3, 8'hA5, 1'b0, 1'b0, 8'hA5};
        tbl[2] = '{1'b0, 1'b0, 8'h12, M_NORMAL, 2, 2, 8'h00, 1'b1, 1'b0, 8'hA5};
        tbl[3] = '{1'b0, 1'b0, 8'h34, M_NORMAL, 1, 4, 8'h00, 1'b0, 1'b0, 8'hA5};
        tbl[4] = '{1'b0, 1'b0, 8'h56, M_NEVER,  3, 3, 8'h00, 1'b0, 1'b1, 8'hA5};
        tbl[5] = '{1'b1, 1'b0, 8'h00, M_NEVER,  3, 3, 8'h77, 1'b0, 1'b1, 8'hA5};
        tbl[6] = '{1'b0, 1'b1, 8'h7E, M_HOLD,   2, 3, 8'h00, 1'b0, 1'b1, 8'hA5};
        tbl[7] = '{1'b1, 1'b0, 8'h00, M_HOLD,   2, 2, 8'hC3, 1'b0, 1'b1, 8'hA5};
        tbl[8] = '{1'b1, 1'b1, 8'h3C, M_NORMAL, 2, 2, 8'h99, 1'b0, 1'b0, 8'hA5};
        tbl[9] = '{1'b1, 1'b0, 8'h00, M_NORMAL, 5, 1, 8'h5A, 1'b0, 1'b0, 8'h5A};

        i_rst = 1'b1; i_cmd_stb = 1'b0; i_cmd_rd = 1'b0; i_cmd_addr = 1'b0;
        i_cmd_data = 8'h00; i_depp = 8'h00; i_wait = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("reset_astb_n", int'(o_astb_n), 1);
        chk("reset_dstb_n", int'(o_dstb_n), 1);
        chk("reset_write_n", int'(o_write_n), 1);
        chk("reset_depp_oe", int'(o_depp_oe), 0);
        chk("reset_depp", int'(o_depp), 0);
        chk("reset_busy", int'(o_cmd_busy), 0);
        chk("reset_rsp_stb", int'(o_rsp_stb), 0);
        chk("reset_rsp_err", int'(o_rsp_err), 0);
        chk("reset_rsp_data", int'(o_rsp_data), 0);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);

        for (int i = 0; i < 10; i++) begin
            run_cmd(tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].mode, tbl[i].rise,
                    tbl[i].fall, tbl[i].resp, tbl[i].poke, tbl[i].exp_err, tbl[i].exp_data);
            model_rsp_data = tbl[i].exp_data;
        end

        // Reset while the data strobe is low: abort without a response.
        i_cmd_rd = 1'b0; i_cmd_addr = 1'b0; i_cmd_data = 8'h99; i_cmd_stb = 1'b1; i_wait = 1'b0;
        @(negedge i_clk);
        i_cmd_stb = 1'b0;
        n = 0;
        while (o_dstb_n && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk("rst_seq_dstb_low", int'(o_dstb_n), 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        model_rsp_data = 8'h00;
        chk("rst_dstb_n", int'(o_dstb_n), 1);
        chk("rst_depp_oe", int'(o_depp_oe), 0);
        chk("rst_busy", int'(o_cmd_busy), 0);
        chk("rst_write_n", int'(o_write_n), 1);
        chk("rst_rsp_data", int'(o_rsp_data), int'(model_rsp_data));
        nrsp = int'(o_rsp_stb);
        repeat (8) begin
            @(negedge i_clk);
            if (o_rsp_stb) nrsp++;
        end
        chk("rst_no_rsp", nrsp, 0);
        hi_run = 1000;
        run_cmd(1'b0, 1'b0, 8'h99, M_NORMAL, 2, 2, 8'h00, 1'b0, 1'b0, model_rsp_data);

        for (int i = 0; i < 12; i++) begin
            r_rd   = 1'($urandom_range(0, 1));
            r_addr = 1'($urandom_range(0, 1));
            r_data = 8'($urandom);
            r_resp = 8'($urandom);
            sel    = int'($urandom_range(0, 7));
            r_mode = (sel == 0) ? M_NEVER : (sel == 1) ? M_HOLD : M_NORMAL;
            r_err  = (r_mode != M_NORMAL);
            if (r_rd && !r_addr && !r_err) model_rsp_data = r_resp;
            run_cmd(r_rd, r_addr, r_data, r_mode, int'($urandom_range(1, 6)),
                    int'($urandom_range(1, 6)), r_resp, 1'b0, r_err, model_rsp_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
